// File: rtl/mlp_ybuf_ctrl.sv
// mlp_ybuf_ctrl: collects per-image class scores from the MLP datapath and
// writes them, one word per handshake, into the output buffer at consecutive
// word-aligned byte addresses. It signals completion with a one-cycle
// interrupt and a sticky LED level.
//
// Optional feature macro: YBUF_ARGMAX_EN. When it is defined, a per-image
// signed argmax tracker drives pred_valid_o/pred_class_o. Otherwise both
// outputs are tied low.
//
// Handshake: res_ready_o is high for the whole RUN state and low everywhere
// else. A score is accepted in any cycle where res_valid_i && res_ready_o.
// The controller applies no backpressure inside RUN.
module mlp_ybuf_ctrl #(
    parameter int IN_IMG_NUM       = 10,
    parameter int CLASS_NUM        = 10,
    parameter int Y_BUF_DATA_WIDTH = 32,
    parameter int Y_BUF_ADDR_WIDTH = 32,
    localparam int CLS_W           = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        start_i,
    input  logic                        res_valid_i,
    input  logic [Y_BUF_DATA_WIDTH-1:0] res_data_i,
    output logic                        res_ready_o,
    output logic                        y_buf_en,
    output logic                        y_buf_wr_en,
    output logic [Y_BUF_ADDR_WIDTH-1:0] y_buf_addr,
    output logic [Y_BUF_DATA_WIDTH-1:0] y_buf_data,
    output logic                        busy_o,
    output logic                        done_intr_o,
    output logic                        done_led_o,
    output logic                        pred_valid_o,
    output logic [CLS_W-1:0]            pred_class_o,
    output logic [1:0]                  dbg_state_o
);

    localparam int TOTAL = IN_IMG_NUM * CLASS_NUM;
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [Y_BUF_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [Y_BUF_DATA_WIDTH-1:0] data_q;
    logic                        wr_q;
    logic                        led_q;
    logic                        hs;
    logic                        last_word;
    logic                        start_run;

    assign hs        = (state_q == S_RUN) && res_valid_i;
    assign last_word = (cnt_q == CNT_W'(TOTAL - 1));
    assign start_run = (state_q == S_IDLE) && start_i;

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and byte address of the word being accepted.
    always_comb begin
        state_d = state_q;
        addr_d  = Y_BUF_ADDR_WIDTH'(cnt_q) << 2;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (hs && last_word) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write path: register the accepted score and address, then strobe once.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q   <= 1'b0;
            cnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wr_q <= hs;
            if (hs) begin
                data_q <= res_data_i;
                addr_q <= addr_d;
                cnt_q  <= cnt_q + 1'b1;
            end else if (start_run) begin
                cnt_q <= '0;
            end
        end
    end

    // Sticky completion level: set entering DONE, cleared when a new run starts.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                 led_q <= 1'b0;
        else if (state_q == S_FLUSH) led_q <= 1'b1;
        else if (start_run)          led_q <= 1'b0;
    end

    assign res_ready_o = (state_q == S_RUN);
    assign busy_o      = (state_q != S_IDLE);
    assign done_intr_o = (state_q == S_DONE);
    assign done_led_o  = led_q;
    assign y_buf_en    = wr_q;
    assign y_buf_wr_en = wr_q;
    assign y_buf_addr  = addr_q;
    assign y_buf_data  = data_q;
    assign dbg_state_o = state_q;

`ifdef YBUF_ARGMAX_EN
    logic signed [Y_BUF_DATA_WIDTH-1:0] max_q, max_d;
    logic [CLS_W-1:0]                   cls_q, idx_q, idx_d, pc_q;
    logic                               pv_q;
    logic                               take_new;
    logic                               last_cls;

    // Running maximum candidate; strict compare keeps the lower index on ties.
    always_comb begin
        last_cls = (cls_q == CLS_W'(CLASS_NUM - 1));
        take_new = (cls_q == '0) || ($signed(res_data_i) > max_q);
        max_d    = take_new ? $signed(res_data_i) : max_q;
        idx_d    = take_new ? cls_q : idx_q;
    end

    // Per-image tracker; publishes the argmax alongside the last class write.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            max_q <= '0;
            cls_q <= '0;
            idx_q <= '0;
            pc_q  <= '0;
            pv_q  <= 1'b0;
        end else begin
            pv_q <= hs && last_cls;
            if (start_run) begin
                cls_q <= '0;
            end else if (hs) begin
                max_q <= max_d;
                idx_q <= idx_d;
                cls_q <= last_cls ? '0 : cls_q + 1'b1;
                if (last_cls) pc_q <= idx_d;
            end
        end
    end

    assign pred_valid_o = pv_q;
    assign pred_class_o = pc_q;
`else
    assign pred_valid_o = 1'b0;
    assign pred_class_o = '0;
`endif

endmodule

// File: tb/tb_mlp_ybuf_ctrl.sv
// Bench for mlp_ybuf_ctrl: drives randomized runs and compares every cycle
// against a run-timeline model kept in this file.
module tb_mlp_ybuf_ctrl;

  localparam int IMG   = 10;
  localparam int CLS   = 10;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int TOTAL = IMG * CLS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0;
  logic valid = 1'b0;
  logic [DW-1:0] data = '0;

  logic          ready, y_en, y_wr, busy, intr, led, pv;
  logic [AW-1:0] y_addr;
  logic [DW-1:0] y_data;
  logic [3:0]    pc;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mlp_ybuf_ctrl #(
    .IN_IMG_NUM(IMG), .CLASS_NUM(CLS),
    .Y_BUF_DATA_WIDTH(DW), .Y_BUF_ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start),
    .res_valid_i(valid), .res_data_i(data), .res_ready_o(ready),
    .y_buf_en(y_en), .y_buf_wr_en(y_wr), .y_buf_addr(y_addr), .y_buf_data(y_data),
    .busy_o(busy), .done_intr_o(intr), .done_led_o(led),
    .pred_valid_o(pv), .pred_class_o(pc), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_intr = 0;
  int intr_cyc = 0;
  int last_wr_cyc = 0;
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  logic [DW-1:0] exp_q[$];
  logic [3:0]    pc_seen[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected outputs for the current cycle plus a coarse run timeline:
  // accepting words, then one write-drain cycle, then one completion cycle.
  logic e_busy, e_ready, e_wr, e_intr, e_led, e_pv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [3:0]    e_pc;
  int m_count;
  int m_tail;
  logic signed [DW-1:0] img[CLS];

  function automatic logic [3:0] argmax();
    int best = 0;
    for (int j = 1; j < CLS; j++) if (img[j] > img[best]) best = j;
    return 4'(best);
  endfunction

  task automatic model_reset();
    e_busy = 0; e_ready = 0; e_wr = 0; e_intr = 0; e_led = 0; e_pv = 0;
    e_addr = '0; e_data = '0; e_pc = '0; m_count = 0; m_tail = 0;
  endtask

  task automatic model_step(input logic st, input logic vl, input logic [DW-1:0] dt);
    logic hs;
    int pos;
    hs = e_ready && vl;
    e_wr = hs;
    e_pv = 0;
    e_intr = 0;
    if (hs) begin
      pos = m_count % CLS;
      e_data = dt;
      e_addr = AW'(m_count * 4);
      img[pos] = dt;
`ifdef YBUF_ARGMAX_EN
      if (pos == CLS - 1) begin
        e_pv = 1;
        e_pc = argmax();
      end
`endif
      m_count++;
    end
    if (!e_busy) begin
      if (st) begin
        e_busy = 1; e_ready = 1; m_count = 0; e_led = 0;
      end
    end else if (e_ready) begin
      if (hs && m_count == TOTAL) begin
        e_ready = 0; m_tail = 1;
      end
    end else if (m_tail == 1) begin
      m_tail = 2; e_intr = 1; e_led = 1;
    end else begin
      m_tail = 0; e_busy = 0;
    end
  endtask

  // ---------------- compare (every cycle) ----------------
  task automatic compare();
    cyc++;
    chk("busy", 64'(busy), 64'(e_busy));
    chk("ready", 64'(ready), 64'(e_ready));
    chk("y_buf_en", 64'(y_en), 64'(e_wr));
    chk("y_buf_wr_en", 64'(y_wr), 64'(e_wr));
    chk("y_buf_addr", 64'(y_addr), 64'(e_addr));
    chk("y_buf_data", 64'(y_data), 64'(e_data));
    chk("done_intr", 64'(intr), 64'(e_intr));
    chk("done_led", 64'(led), 64'(e_led));
    chk("pred_valid", 64'(pv), 64'(e_pv));
    chk("pred_class", 64'(pc), 64'(e_pc));
    if (y_wr === 1'b1) begin
      wr_a.push_back(y_addr);
      wr_d.push_back(y_data);
      last_wr_cyc = cyc;
    end
    if (intr === 1'b1) begin
      n_intr++;
      intr_cyc = cyc;
    end
    if (pv === 1'b1) pc_seen.push_back(pc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic st, input logic vl, input logic [DW-1:0] dt);
    start = st; valid = vl; data = dt;
    @(posedge clk);
    model_step(st, vl, dt);
    @(negedge clk);
    compare();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy === 1'b1; k++) cycle(1'b0, 1'b0, '0);
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic clear_capture();
    wr_a.delete(); wr_d.delete(); exp_q.delete(); n_intr = 0;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_en"}, 64'(y_en), 64'd0);
    chk({tag, "_wr"}, 64'(y_wr), 64'd0);
    chk({tag, "_addr"}, 64'(y_addr), 64'd0);
    chk({tag, "_data"}, 64'(y_data), 64'd0);
    chk({tag, "_intr"}, 64'(intr), 64'd0);
    chk({tag, "_led"}, 64'(led), 64'd0);
    chk({tag, "_pv"}, 64'(pv), 64'd0);
    chk({tag, "_pc"}, 64'(pc), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent;
    int errs;
    logic st;
    logic vl;
    logic [DW-1:0] dt;
    logic signed [DW-1:0] img0[CLS];

    model_reset();
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_zero("por");
    rstn = 1'b1;

    // A: start pulse, 100 back-to-back scores 0..99
    clear_capture();
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < TOTAL; i++) begin
      exp_q.push_back(DW'(i));
      cycle(1'b0, 1'b1, DW'(i));
    end
    wait_idle();
    chk("a_nwr", 64'(wr_a.size()), 64'd100);
    if (wr_a.size() == TOTAL) begin
      chk("a_first_addr", 64'(wr_a[0]), 64'd0);
      chk("a_last_addr", 64'(wr_a[TOTAL-1]), 64'd396);
      chk("a_last_data", 64'(wr_d[TOTAL-1]), 64'd99);
      errs = 0;
      for (int i = 0; i < TOTAL; i++)
        if (wr_d[i] !== exp_q[i] || wr_a[i] !== AW'(4 * i)) errs++;
      chk("a_seq", 64'(errs), 64'd0);
    end
    chk("a_nintr", 64'(n_intr), 64'd1);
    chk("a_intr_delay", 64'(intr_cyc - last_wr_cyc), 64'd1);
    chk("a_led", 64'(led), 64'd1);

    // B: random gaps, random data, stray start pulses during the run
    clear_capture();
    cycle(1'b1, 1'b0, '0);
    for (int k = 0; k < 2000 && m_count < TOTAL; k++) begin
      vl = ($urandom_range(0, 2) != 0);
      st = ($urandom_range(0, 3) == 0);
      dt = $urandom();
      cycle(st, vl, dt);
    end
    wait_idle();
    chk("b_nwr", 64'(wr_a.size()), 64'd100);
    errs = 0;
    foreach (wr_a[i]) if (wr_a[i] !== AW'(4 * i)) errs++;
    chk("b_addr_seq", 64'(errs), 64'd0);
    chk("b_nintr", 64'(n_intr), 64'd1);

    // C: valid while idle (ignored), then start held high across a run end
    clear_capture();
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, $urandom());
    chk("c_idle_nwr", 64'(wr_a.size()), 64'd0);
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < TOTAL; i++) cycle(1'b1, 1'b1, $urandom());
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, '0);
    chk("c_restart_busy", 64'(busy), 64'd1);
    for (int i = 0; i < TOTAL; i++) cycle(1'b0, 1'b1, $urandom());
    wait_idle();
    chk("c_nwr", 64'(wr_a.size()), 64'd200);
    chk("c_nintr", 64'(n_intr), 64'd2);

    // D: reset after 37 words, then a fresh run starts from address 0
    clear_capture();
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 37; i++) cycle(1'b0, 1'b1, $urandom());
    rstn = 1'b0;
    #1;
    check_reset_zero("mid");
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clear_capture();
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, $urandom());
    chk("d_wait_start", 64'(wr_a.size()), 64'd0);
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < TOTAL; i++) cycle(1'b0, 1'b1, $urandom());
    wait_idle();
    chk("d_nwr", 64'(wr_a.size()), 64'd100);
    if (wr_a.size() > 0) chk("d_first_addr", 64'(wr_a[0]), 64'd0);

    // E: argmax on a known first image, random remaining images
    img0 = '{-5, 3, 9, 9, -1, 0, 0, 0, 0, 0};
    pc_seen.delete();
    clear_capture();
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < TOTAL; i++) begin
      dt = (i < CLS) ? DW'(img0[i]) : $urandom();
      cycle(1'b0, 1'b1, dt);
    end
    wait_idle();
`ifdef YBUF_ARGMAX_EN
    chk("e_npred", 64'(pc_seen.size()), 64'(IMG));
    if (pc_seen.size() > 0) chk("e_img0_class", 64'(pc_seen[0]), 64'd2);
`else
    chk("e_npred", 64'(pc_seen.size()), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlp_ybuf_ctrl.md
MLP_YBUF_CTRL -- requirements
Module: mlp_ybuf_ctrl

Interface
REQ-001 Parameter IN_IMG_NUM, default 10: number of images per inference run.
REQ-002 Parameter CLASS_NUM, default 10: number of output scores per image.
REQ-003 Parameter Y_BUF_DATA_WIDTH, default 32: width of the score word and the output-buffer data.
REQ-004 Parameter Y_BUF_ADDR_WIDTH, default 32: width of the output-buffer byte address.
REQ-005 Port clk_i  input  1: single clock; all logic on its rising edge.
REQ-006 Port rstn_i  input  1: reset, asynchronous, active-low.
REQ-007 Port start_i  input  1: begin a run; sampled only in IDLE.
REQ-008 Port res_valid_i  input  1: datapath score valid.
REQ-009 Port res_data_i  input  Y_BUF_DATA_WIDTH: signed score; order is image-major, class-minor.
REQ-010 Port res_ready_o  output  1: controller accepts a score.
REQ-011 Port y_buf_en, y_buf_wr_en  output  1 each: output-buffer enable and write strobe.
REQ-012 Port y_buf_addr  output  Y_BUF_ADDR_WIDTH: byte address, word-aligned.
REQ-013 Port y_buf_data  output  Y_BUF_DATA_WIDTH: write data.
REQ-014 Port busy_o  output  1: high in any state other than IDLE.
REQ-015 Port done_intr_o  output  1: one-cycle completion pulse.
REQ-016 Port done_led_o  output  1: sticky completion level.
REQ-017 Ports pred_valid_o (1) and pred_class_o ($clog2(CLASS_NUM))  output: per-image argmax result (see Configuration).

Function
REQ-018 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-019 FSM transitions:
- IDLE -> RUN when start_i=1.
- RUN -> FLUSH on the handshake of word number IN_IMG_NUM*CLASS_NUM.
- FLUSH -> DONE after one cycle.
- DONE -> IDLE after one cycle.
REQ-020 res_ready_o=1 only in RUN; a handshake is the cycle where res_valid_i=1 and res_ready_o=1.
REQ-021 Write timing: a handshake in cycle n produces y_buf_en=y_buf_wr_en=1 in cycle n+1, with y_buf_data=res_data_i registered in cycle n; strobes are 0 in every other cycle.
REQ-022 Address rule: y_buf_addr = word_index*4, where word_index counts 0..IN_IMG_NUM*CLASS_NUM-1 (0 to 396 at default parameters); the address holds its last value between writes.
REQ-023 The word counter clears on the IDLE->RUN transition and never wraps within a run; no word is accepted after the last one.
REQ-024 done_intr_o=1 for exactly the DONE cycle, i.e. one cycle after the final write strobe.
REQ-025 done_led_o sets in DONE and clears on the next IDLE->RUN transition.
REQ-026 start_i is ignored in RUN, FLUSH and DONE; start_i held high in IDLE after DONE launches a new run.
REQ-027 res_valid_i asserted outside RUN is ignored: no write occurs and no counter advances.
REQ-028 Backpressure-free: res_ready_o never drops inside RUN, so any number of gap cycles with res_valid_i=0 is tolerated.

Reset
REQ-029 While rstn_i=0, all of the following are forced immediately, regardless of clock:
- FSM to IDLE.
- Word counter and address to 0.
- y_buf_data to 0.
- res_ready_o, y_buf_en, y_buf_wr_en, busy_o, done_intr_o, done_led_o, pred_valid_o and pred_class_o to 0.
REQ-030 Reset mid-run abandons the run; after release the block waits for a fresh start_i.

Configuration
REQ-031 Macro YBUF_ARGMAX_EN controls a per-image argmax tracker.
REQ-032 With YBUF_ARGMAX_EN defined:
- A running signed maximum and its index are tracked per image; ties keep the lower class index.
- pred_valid_o pulses in the write cycle of each image's last class score.
- pred_class_o carries that image's argmax in the same cycle and holds until the next pulse.
REQ-033 Without YBUF_ARGMAX_EN defined: the argmax logic is absent, and pred_valid_o and pred_class_o are tied to 0.

Verification
REQ-034 Reset then start_i one cycle; 100 back-to-back valid scores 0..99 -> 100 writes at addresses 0,4,...,396 with data 0..99, done_intr_o a single pulse one cycle after the last write, done_led_o=1.
REQ-035 Random res_valid_i gaps during a run -> write count, ordering and addresses identical to the back-to-back case.
REQ-036 res_valid_i=1 while IDLE, and start_i pulses during RUN -> no extra writes, counter unaffected.
REQ-037 rstn_i low after 37 words -> all outputs 0 immediately; a new start writes again from address 0.
REQ-038 YBUF_ARGMAX_EN defined; image 0 scores {-5,3,9,9,-1,0,0,0,0,0} -> pred_valid_o with pred_class_o=2; undefined -> pred_valid_o always 0.
